// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and helpers for the writeback arbiter.
//   exe_bundle_t : completed execution result; valid iff opid[15].
//   red_bundle_t : redirect bundle; opid[15] = valid, topid = oldest in-flight op.
//   idx_w        : index width helper (never below 1 bit).
//   opid_younger : age test of an op against a redirect, also used by the
//                  execution queues' bubble logic.
package wb_arbiter_pkg;

    typedef struct packed {
        logic [15:0] opid;
        logic [6:0]  prd;
        logic [31:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Ages are distances from topid in a 'bits'-wide window, so the
    // comparison survives opid wrap-around. The +1 is taken inside the
    // window too: the redirecting op itself is never younger than itself.
    function automatic logic opid_younger(red_bundle_t redir, logic [15:0] opid,
                                          int unsigned bits);
        logic [15:0] mask;
        logic [15:0] d_e;
        logic [15:0] d_r;
        mask = 16'((32'd1 << bits) - 32'd1);
        d_e  = (opid - redir.topid) & mask;
        d_r  = (redir.opid - redir.topid + 16'd1) & mask;
        return redir.opid[15] & opid[15] & (d_e >= d_r);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus between the FU output queues / writeback consumers and
// the arbiter.
//   redir    : redirect bundle
//   fu_resp  : FU queue heads [nfu][ewd]
//   fu_claim : claim (pop) strobes back to the FU queues [nfu][ewd]
//   wb_stall : downstream cannot accept writebacks this cycle
//   wb       : registered writeback slots [ewd]
// Modport master is the arbiter side, slave the surrounding pipeline side.
interface wb_arbiter_if #(
    parameter int unsigned ewd = 2,
    parameter int unsigned nfu = 3
) ();
    import wb_arbiter_pkg::*;

    red_bundle_t                       redir;
    exe_bundle_t [nfu-1:0][ewd-1:0]    fu_resp;
    logic        [nfu-1:0][ewd-1:0]    fu_claim;
    logic                              wb_stall;
    exe_bundle_t [ewd-1:0]             wb;

    modport master (
        input  redir, fu_resp, wb_stall,
        output fu_claim, wb
    );

    modport slave (
        output redir, fu_resp, wb_stall,
        input  fu_claim, wb
    );

endinterface

// File: rtl/wb_arbiter_select.sv
// wb_select: combinational round-robin prefix selector.
//   valid_i    : entry valid matrix [nfu][ewd]
//   rr_i       : FU to visit first
//   claim_o    : granted entries; always a contiguous prefix per FU
//   slot_vld_o : writeback slot s receives a grant
//   slot_fu_o  : source FU of slot s
//   slot_idx_o : source entry index of slot s
//   last_fu_o  : FU of the last grant made
//   any_gnt_o  : at least one grant made
module wb_select #(
    parameter int unsigned ewd = 2,
    parameter int unsigned nfu = 3
) (
    input  logic [nfu-1:0][ewd-1:0]                            valid_i,
    input  logic [wb_arbiter_pkg::idx_w(nfu)-1:0]              rr_i,
    output logic [nfu-1:0][ewd-1:0]                            claim_o,
    output logic [ewd-1:0]                                     slot_vld_o,
    output logic [ewd-1:0][wb_arbiter_pkg::idx_w(nfu)-1:0]     slot_fu_o,
    output logic [ewd-1:0][wb_arbiter_pkg::idx_w(ewd)-1:0]     slot_idx_o,
    output logic [wb_arbiter_pkg::idx_w(nfu)-1:0]              last_fu_o,
    output logic                                               any_gnt_o
);
    import wb_arbiter_pkg::*;

    localparam int unsigned FW = idx_w(nfu);
    localparam int unsigned IW = idx_w(ewd);
    localparam int unsigned CW = IW + 1;

    logic [CW-1:0] cnt;
    logic          run;

    // The rotation is done as two static passes (f >= rr, then f < rr) so
    // that every array index stays a loop constant.
    always_comb begin
        claim_o    = '0;
        slot_vld_o = '0;
        slot_fu_o  = '0;
        slot_idx_o = '0;
        last_fu_o  = '0;
        any_gnt_o  = 1'b0;
        cnt        = '0;
        run        = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned f = 0; f < nfu; f++) begin
                if ((p == 0) == (f >= 32'(rr_i))) begin
                    run = 1'b1;
                    for (int unsigned i = 0; i < ewd; i++) begin
                        if (run && valid_i[f][i] && (cnt < CW'(ewd))) begin
                            claim_o[f][i] = 1'b1;
                            for (int unsigned s = 0; s < ewd; s++) begin
                                if (cnt == CW'(s)) begin
                                    slot_vld_o[s] = 1'b1;
                                    slot_fu_o[s]  = FW'(f);
                                    slot_idx_o[s] = IW'(i);
                                end
                            end
                            last_fu_o = FW'(f);
                            any_gnt_o = 1'b1;
                            cnt       = cnt + CW'(1);
                        end else begin
                            run = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: claims up to ewd completed results per cycle from nfu FU output
// queues in round-robin FU order and registers them into ewd writeback slots.
// Results younger than an active redirect are consumed but written back with
// opid = 0.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : wb_arbiter_if master (redir, fu_resp, fu_claim, wb_stall, wb)
//   perf_starve : (WB_PERF_EN) cycles with full grants and leftover valid work
//   perf_squash : (WB_PERF_EN) number of squashed grants
// Build macro WB_PERF_EN adds the saturating performance counters.
module wb_arbiter #(
    parameter int unsigned ewd  = 2,
    parameter int unsigned nfu  = 3,
    parameter int unsigned opsz = 64
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.master  bus
`ifdef WB_PERF_EN
    ,
    output logic [31:0]   perf_starve,
    output logic [31:0]   perf_squash
`endif
);
    import wb_arbiter_pkg::*;

    localparam int unsigned FW = idx_w(nfu);
    localparam int unsigned IW = idx_w(ewd);
    localparam int unsigned OB = $clog2(opsz);

    logic        [nfu-1:0][ewd-1:0] vld;
    logic        [nfu-1:0][ewd-1:0] claim;
    logic        [ewd-1:0]          slot_vld;
    logic        [ewd-1:0][FW-1:0]  slot_fu;
    logic        [ewd-1:0][IW-1:0]  slot_idx;
    logic        [FW-1:0]           last_fu;
    logic                           any_gnt;
    logic        [ewd-1:0]          sq;
    exe_bundle_t [ewd-1:0]          wb_q, wb_d;
    logic        [FW-1:0]           rr_q, rr_d;

    always_comb begin
        vld = '0;
        for (int unsigned f = 0; f < nfu; f++) begin
            for (int unsigned i = 0; i < ewd; i++) begin
                vld[f][i] = bus.fu_resp[f][i].opid[15];
            end
        end
    end

    wb_select #(
        .ewd (ewd),
        .nfu (nfu)
    ) u_sel (
        .valid_i    (vld),
        .rr_i       (rr_q),
        .claim_o    (claim),
        .slot_vld_o (slot_vld),
        .slot_fu_o  (slot_fu),
        .slot_idx_o (slot_idx),
        .last_fu_o  (last_fu),
        .any_gnt_o  (any_gnt)
    );

    always_comb begin
        bus.fu_claim = bus.wb_stall ? '0 : claim;
        bus.wb       = wb_q;
    end

    always_comb begin
        wb_d = wb_q;
        sq   = '0;
        rr_d = rr_q;
        if (bus.wb_stall) begin
            // Held slots stay in place; younger ones are only invalidated.
            for (int unsigned s = 0; s < ewd; s++) begin
                if (opid_younger(bus.redir, wb_q[s].opid, OB)) begin
                    wb_d[s].opid = '0;
                end
            end
        end else begin
            for (int unsigned s = 0; s < ewd; s++) begin
                wb_d[s] = '0;
                if (slot_vld[s]) begin
                    wb_d[s] = bus.fu_resp[slot_fu[s]][slot_idx[s]];
                    if (opid_younger(bus.redir, wb_d[s].opid, OB)) begin
                        wb_d[s].opid = '0;
                        sq[s]        = 1'b1;
                    end
                end
            end
            if (any_gnt) begin
                rr_d = (last_fu == FW'(nfu - 1)) ? '0 : last_fu + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
            rr_q <= '0;
        end else begin
            wb_q <= wb_d;
            rr_q <= rr_d;
        end
    end

`ifdef WB_PERF_EN
    logic [31:0] starve_q, starve_d;
    logic [31:0] squash_q, squash_d;
    logic [32:0] squash_sum;

    always_comb begin
        starve_d   = starve_q;
        squash_sum = {1'b0, squash_q} + 33'($countones(sq));
        squash_d   = squash_sum[32] ? '1 : squash_sum[31:0];
        if (!bus.wb_stall && (&slot_vld) && (|(vld & ~claim)) && (starve_q != '1)) begin
            starve_d = starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            squash_q <= '0;
        end else begin
            starve_q <= starve_d;
            squash_q <= squash_d;
        end
    end

    assign perf_starve = starve_q;
    assign perf_squash = squash_q;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Downstream stage of the integer/system execution queue and its sibling functional-unit output queues.
- Each cycle it claims up to ewd completed exe_bundle_t results across nfu FU output ports, using a round-robin FU priority.
- Selected results are registered into ewd writeback slots that feed the PRF write ports and the commit module.
- Results younger than an active redirect are dropped.

Parameters:
- ewd, 2, writeback width; also the per-FU response width.
- nfu, 3, number of FU output queues arbitrated. FU 0 is the ALU.
- opsz, 64, operation-ID window size. Only the low $clog2(opsz) bits are used for ordering.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- redir  input  red_bundle_t  redirect bundle. opid[15] = valid; topid = oldest in-flight op.
- fu_resp  input  [nfu-1:0][ewd-1:0] exe_bundle_t  FU queue heads. An entry is valid iff opid[15].
- fu_claim  output  [nfu-1:0][ewd-1:0]  claim signals back to the FU queues.
- wb_stall  input  1  downstream cannot accept new writebacks this cycle.
- wb  output  [ewd-1:0] exe_bundle_t  registered writeback slots. A slot is valid iff opid[15].

Behaviour:
- Reset: wb all zero; rr pointer = 0; perf counters = 0. Reset is asynchronous, so state clears immediately regardless of clk.
- Latency: exactly 1 cycle from claim to the wb register.
- fu_claim and the selection are purely combinational from fu_resp, rr, wb_stall and redir.
- Selection order:
  - Visit FUs starting at rr, in the order rr, rr+1, ... wrapping modulo nfu.
  - Within FU f, take entries i = 0, 1, ... while fu_resp[f][i] is valid and total grants < ewd.
  - Stop at FU f's first invalid entry, so claims per FU are always a contiguous prefix from index 0 (required by the queue pop logic).
  - Granted entries fill wb slots 0.. in grant order. Unused slots have opid = 0.
- Squash:
  - An entry is younger than the redirect iff redir.opid[15] & e.opid[15] & (e.opid - topid) >= (redir.opid - topid) + 1, computed in $clog2(opsz) bits with wrap-around.
  - Younger entries that are granted are still claimed (consumed) but written to wb with opid = 0.
  - They still occupy a grant slot, so grant count is unaffected.
- Stall (wb_stall = 1):
  - All fu_claim = 0 and wb holds its value.
  - If redir is valid during the stall, held wb slots that are younger get opid cleared at the edge. Slot compaction is not required.
  - rr does not advance.
- rr update: when not stalled and at least one grant is made, rr <= (last granted FU + 1) mod nfu. With zero grants, rr holds.
- Boundaries:
  - All FUs empty: wb <= all zero.
  - Exactly ewd grants available from one FU: all of them come from that FU; the others get no claim.
  - nfu = 1: rr is constant 0.
  - redir valid with redir.opid == e.opid: the entry is not younger and is kept (the redirecting op itself writes back).

Optional Feature:
- WB_PERF_EN:
  - Adds output perf_starve [31:0]: cycles in which ewd grants were made but at least one valid unclaimed fu_resp entry remained.
  - Adds output perf_squash [31:0]: count of squashed grants.
  - Both counters saturate at all-ones and reset to 0.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- Types package:
  - exe_bundle_t and red_bundle_t (existing).
  - New function opid_younger(redir, opid, opsz bits), shared with the execution queues' bubble logic.
- Sub-module wb_select: purely combinational round-robin prefix selector. Inputs are the valid matrix and rr; outputs are the claim matrix, the per-slot source index {f, i}, and the last granted FU.
- wb_arbiter owns the registers, squash logic, stall handling and perf counters.

Test Plan:
- Reset mid-run: assert rst asynchronously between edges with wb holding valid entries → wb reads 0 immediately; after release, rr = 0.
- nfu=3, ewd=2, rr=0:
  - FU0 has 1 valid, FU1 has 2 valid → claim FU0[0] and FU1[0].
  - Next cycle wb = {FU0 op, FU1 op}; rr becomes 2.
- FU0 entries 0 and 1 both valid (opid 0x8005, 0x8006), other FUs empty → claims 2'b11 on FU0; next cycle wb[0].opid = 0x8005, wb[1].opid = 0x8006.
- redir.opid = 0x8004, topid = 0x8000, FU1 offers 0x8003 and 0x8009 → both claimed; wb[0].opid = 0x8003, wb[1].opid = 0.
- Wrap-around: topid = 0x803E, redir.opid = 0x803F, entry opid 0x8001 → treated as younger and squashed. Entry 0x803E → kept.
- wb_stall = 1 for 3 cycles with valid inputs → no claims, wb stable, rr stable. Redir in the 2nd stall cycle clears the younger held slot.
